vpu_issue_ctrl: RTL and testbench
=================================

Name: vpu_issue_ctrl

Overview:
- VPU-side responder for the CPU's VPU_start / VPU_rdy stall handshake.
- Accepts one vector instruction at a time, latches its fields, and sequences per-element execution over the vector register file (VRF) and data memory.
- Holds VPU_rdy low until the instruction retires, which stalls the CPU pipeline.
- Sits between the CPU control path and the VPU lane datapath / memory arbiter.

Parameters:
- VLEN, 8, elements per vector register; one element processed per step.
- IDX_W, 3, element index width; must satisfy 2^IDX_W >= VLEN.
- AW, 16, memory address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- VPU_start  in  1  CPU requests a vector instruction; held high while the CPU is stalled.
- opcode  in  5  instruction opcode.
- vd  in  3  destination vector register.
- vs  in  3  source vector register A.
- vt  in  3  source vector register B / store source.
- base_addr  in  AW  scalar base address for VLD/VST.
- mem_ack  in  1  memory accepted or returned the current element.
- VPU_rdy  out  1  VPU can accept a new instruction; 0 stalls the CPU.
- lane_op  out  3  lane ALU function = latched opcode[2:0].
- vrf_ra  out  3  VRF read register A (latched vs).
- vrf_rb  out  3  VRF read register B (latched vt).
- vrf_wa  out  3  VRF write register (latched vd).
- vrf_we  out  1  VRF write strobe for element elem_idx.
- elem_idx  out  IDX_W  current element index.
- mem_req  out  1  element memory request.
- mem_we  out  1  1 = store, 0 = load; valid while mem_req is high.
- mem_addr  out  AW  base + elem_idx, modulo 2^AW.
- vpu_err  out  1  last accepted instruction was illegal.

Behaviour:
- States:
  - IDLE: waiting for an instruction.
  - EXEC: lane ALU ops, opcodes 10000–10111.
  - MEM: VLD = 11000, VST = 11001.
  - DONE: one-cycle retire.
- Accept: in IDLE, VPU_start = 1 captures opcode, vd, vs, vt and base_addr on that edge. Sets elem_idx = 0. Clears vpu_err.
- VPU_rdy (Mealy): 1 when (IDLE and ~VPU_start) or DONE; 0 otherwise. It is 0 in the accept cycle itself, so the CPU stalls without a bubble.
- VPU_start is ignored in EXEC, MEM and DONE. The CPU still holds the retiring instruction during DONE, so that cycle must not re-accept it. DONE always goes to IDLE.
- EXEC:
  - vrf_we = 1 every cycle; elem_idx increments by 1 per cycle.
  - At elem_idx = VLEN-1 -> DONE.
  - Timing: accept at edge T; EXEC for VLEN cycles; VPU_rdy = 1 in cycle T+VLEN+1.
- MEM:
  - mem_req = 1 continuously; mem_we = 1 for VST, 0 for VLD.
  - mem_addr = base + elem_idx. Wraps, so 0xFFFF + 1 = 0x0000.
  - Each cycle with mem_ack = 1 completes one element. VLD also asserts vrf_we in that same cycle. elem_idx then increments.
  - mem_ack = 0: hold state, index and address; no timeout.
  - Ack on last element -> DONE; mem_req is 0 in DONE.
- Illegal opcode: 00000–01111, 11010–11111.
  - IDLE -> DONE directly; no vrf_we and no mem_req.
  - vpu_err = 1, sticky until the next accept.
- Outputs when not in EXEC/MEM: vrf_we = 0, mem_req = 0, mem_we = 0. lane_op and the vrf_* register selects hold their latched values.
- Reset (any state, including mid-EXEC or mid-MEM): next edge enters IDLE and zeroes elem_idx, all latched fields, vpu_err, mem_req and vrf_we. VPU_rdy = ~VPU_start after reset.
- Widths: the elem_idx counter never exceeds VLEN-1. The address add is computed as AW bits; the carry is dropped.

Test Plan:
- Reset, VPU_start = 0 -> VPU_rdy = 1; mem_req = 0, vrf_we = 0, vpu_err = 0.
- VADD (10000), vd = 2, vs = 1, vt = 3, start held while rdy = 0 -> rdy = 0 for 9 cycles (accept cycle + 8 EXEC). vrf_we high for 8 cycles with elem_idx 0..7, vrf_wa = 2, lane_op = 000. rdy = 1 in DONE; no re-accept; IDLE next cycle.
- VLD (11000), base = 0xFFFC, mem_ack toggling 1,0,1,0… -> mem_addr sequence FFFC, FFFD, FFFE, FFFF, 0000–0003. Each address held across the ack = 0 cycle. 8 vrf_we pulses, each coincident with ack. DONE after the 8th ack.
- VST (11001) with mem_ack tied to 1 -> mem_we = 1 and mem_req high for exactly 8 cycles; no vrf_we; rdy = 1 in cycle T+9.
- Opcode 11010 with start -> rdy = 0 for one cycle, DONE with vpu_err = 1. Next legal accept clears vpu_err.
- rst = 1 at EXEC elem_idx = 4 -> IDLE next edge, elem_idx = 0, vrf_we = 0. A new start after rst drops is accepted normally.

Source files
------------

// File: rtl/vpu_issue_ctrl.sv
// VPU issue controller: accepts one vector instruction per VPU_start/VPU_rdy
// handshake and steps through its elements over the lane ALU or data memory.
`timescale 1ns/1ps
module vpu_issue_ctrl #(
  parameter int unsigned VLEN  = 8,
  parameter int unsigned IDX_W = 3,
  parameter int unsigned AW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             VPU_start,
  input  logic [4:0]       opcode,
  input  logic [2:0]       vd,
  input  logic [2:0]       vs,
  input  logic [2:0]       vt,
  input  logic [AW-1:0]    base_addr,
  input  logic             mem_ack,
  output logic             VPU_rdy,
  output logic [2:0]       lane_op,
  output logic [2:0]       vrf_ra,
  output logic [2:0]       vrf_rb,
  output logic [2:0]       vrf_wa,
  output logic             vrf_we,
  output logic [IDX_W-1:0] elem_idx,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic             vpu_err
);

  typedef enum logic [1:0] {StIdle, StExec, StMem, StDone} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(VLEN - 1);

  state_e           r_state;
  logic [4:0]       r_op;
  logic [2:0]       r_vd;
  logic [2:0]       r_vs;
  logic [2:0]       r_vt;
  logic [AW-1:0]    r_base;
  logic [IDX_W-1:0] r_idx;
  logic             r_err;

  logic w_is_alu;
  logic w_is_mem;
  logic w_last;

  // Opcode classes: 10xxx lane ALU, 1100x VLD/VST, everything else illegal.
  assign w_is_alu = (opcode[4:3] == 2'b10);
  assign w_is_mem = (opcode[4:1] == 4'b1100);
  assign w_last   = (r_idx == LastIdx);

  // Sequencer: accept, per-element stepping and one-cycle retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_op    <= '0;
      r_vd    <= '0;
      r_vs    <= '0;
      r_vt    <= '0;
      r_base  <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (VPU_start) begin
            r_op   <= opcode;
            r_vd   <= vd;
            r_vs   <= vs;
            r_vt   <= vt;
            r_base <= base_addr;
            r_idx  <= '0;
            r_err  <= ~(w_is_alu | w_is_mem);
            if (w_is_alu)      r_state <= StExec;
            else if (w_is_mem) r_state <= StMem;
            else               r_state <= StDone;
          end
        end
        StExec: begin
          if (w_last) r_state <= StDone;
          else        r_idx   <= r_idx + 1'b1;
        end
        StMem: begin
          // No ack: hold index and therefore address.
          if (mem_ack) begin
            if (w_last) r_state <= StDone;
            else        r_idx   <= r_idx + 1'b1;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  // Handshake and datapath strobes decoded from the current state.
  always_comb begin
    VPU_rdy = ((r_state == StIdle) && !VPU_start) || (r_state == StDone);
    mem_req = (r_state == StMem);
    mem_we  = (r_state == StMem) && r_op[0];
    vrf_we  = (r_state == StExec) || ((r_state == StMem) && mem_ack && !r_op[0]);
  end

  assign lane_op  = r_op[2:0];
  assign vrf_ra   = r_vs;
  assign vrf_rb   = r_vt;
  assign vrf_wa   = r_vd;
  assign elem_idx = r_idx;
  assign vpu_err  = r_err;
  // Carry out of the AW-bit add is dropped so the address wraps.
  assign mem_addr = r_base + AW'(r_idx);

endmodule

// File: tb/tb_vpu_issue_ctrl.sv
// Scoreboard bench for vpu_issue_ctrl: a driver pushes the expected element
// and retire events from a reference model; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_vpu_issue_ctrl;

  localparam int VLEN = 8;

  typedef struct packed {
    logic [1:0]  kind;   // 0 vrf write, 1 memory handshake, 2 retire
    logic [15:0] addr;
    logic [2:0]  wa;
    logic [2:0]  idx;
    logic [2:0]  op;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic        we;
    logic        err;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        VPU_start = 1'b0;
  logic [4:0]  opcode = '0;
  logic [2:0]  vd = '0, vs = '0, vt = '0;
  logic [15:0] base_addr = '0;
  logic        mem_ack = 1'b0;
  logic        VPU_rdy;
  logic [2:0]  lane_op, vrf_ra, vrf_rb, vrf_wa;
  logic        vrf_we;
  logic [2:0]  elem_idx;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic        vpu_err;

  int n_pass = 0;
  int n_total = 0;
  int ack_mode = 1;  // 0 random, 1 tied high, 2 toggling
  ev_t exp_q[$];

  vpu_issue_ctrl #(.VLEN(8), .IDX_W(3), .AW(16)) dut (
    .clk(clk), .rst(rst), .VPU_start(VPU_start), .opcode(opcode), .vd(vd), .vs(vs), .vt(vt),
    .base_addr(base_addr), .mem_ack(mem_ack), .VPU_rdy(VPU_rdy), .lane_op(lane_op),
    .vrf_ra(vrf_ra), .vrf_rb(vrf_rb), .vrf_wa(vrf_wa), .vrf_we(vrf_we), .elem_idx(elem_idx),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .vpu_err(vpu_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic ev_t mk(input logic [1:0] kind, input logic [15:0] addr,
                             input logic [2:0] wa, input logic [2:0] idx, input logic [2:0] op,
                             input logic [2:0] ra, input logic [2:0] rb, input logic we,
                             input logic err);
    ev_t e;
    e.kind = kind; e.addr = addr; e.wa = wa; e.idx = idx; e.op = op;
    e.ra = ra; e.rb = rb; e.we = we; e.err = err;
    return e;
  endfunction

  // Reference model: what one instruction should produce, element by element.
  function automatic void model(input logic [4:0] op, input logic [2:0] d, input logic [2:0] s,
                                input logic [2:0] t, input logic [15:0] base);
    int code = int'(op);
    if (code >= 16 && code <= 23) begin
      for (int i = 0; i < VLEN; i++) exp_q.push_back(mk(2'd0, 16'd0, d, 3'(i), op[2:0], s, t, 1'b0, 1'b0));
      exp_q.push_back(mk(2'd2, 16'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0));
    end else if (code == 24 || code == 25) begin
      for (int i = 0; i < VLEN; i++) begin
        exp_q.push_back(mk(2'd1, 16'((int'(base) + i) % 65536), 3'd0, 3'(i), 3'd0, 3'd0, 3'd0,
                           code == 25, 1'b0));
        if (code == 24) exp_q.push_back(mk(2'd0, 16'd0, d, 3'(i), op[2:0], s, t, 1'b0, 1'b0));
      end
      exp_q.push_back(mk(2'd2, 16'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0));
    end else begin
      exp_q.push_back(mk(2'd2, 16'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1));
    end
  endfunction

  task automatic observe(input ev_t e);
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_event: got %h expected none", e);
    end else begin
      chk("event", 64'(e), 64'(exp_q.pop_front()));
    end
  endtask

  // Memory acknowledge generator.
  always @(posedge clk) begin
    #1;
    case (ack_mode)
      0:       mem_ack = 1'($urandom_range(0, 1));
      1:       mem_ack = 1'b1;
      default: mem_ack = ~mem_ack;
    endcase
  end

  // Monitor: turn DUT activity into events and compare against the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1 && mem_ack)
        observe(mk(2'd1, mem_addr, 3'd0, elem_idx, 3'd0, 3'd0, 3'd0, mem_we, 1'b0));
      if (vrf_we === 1'b1)
        observe(mk(2'd0, 16'd0, vrf_wa, elem_idx, lane_op, vrf_ra, vrf_rb, 1'b0, 1'b0));
      if (VPU_rdy === 1'b1 && VPU_start)
        observe(mk(2'd2, 16'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, vpu_err));
    end
  end

  // Caller is aligned just after a rising edge; returns just after the retire edge.
  task automatic issue(input logic [4:0] op, input logic [2:0] d, input logic [2:0] s,
                       input logic [2:0] t, input logic [15:0] base, input bit chk_stall);
    int stall = 0;
    int cyc = 0;
    bit legal = (op[4:3] == 2'b10) || (op[4:1] == 4'b1100);
    model(op, d, s, t, base);
    VPU_start = 1'b1; opcode = op; vd = d; vs = s; vt = t; base_addr = base;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) begin
        chk("err_after_accept", 64'(vpu_err), 64'(!legal));
        chk("idx_after_accept", 64'(elem_idx), 64'd0);
      end
      if (VPU_rdy) break;
      stall++;
      if (cyc > 300) begin
        n_total++;
        $display("FAIL retire_timeout: got no retire expected VPU_rdy within 300 cycles");
        break;
      end
    end
    if (chk_stall) chk("stall_cycles", 64'(stall), legal ? 64'(VLEN + 1) : 64'd1);
    @(posedge clk); #1;
    VPU_start = 1'b0;
  endtask

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_rdy", 64'(VPU_rdy), 64'd1);
    chk("reset_mem_req", 64'(mem_req), 64'd0);
    chk("reset_vrf_we", 64'(vrf_we), 64'd0);
    chk("reset_err", 64'(vpu_err), 64'd0);
    chk("reset_idx", 64'(elem_idx), 64'd0);
    @(posedge clk); #1;

    ack_mode = 1;
    issue(5'b10000, 3'd2, 3'd1, 3'd3, 16'h0000, 1'b1);     // VADD
    ack_mode = 2;
    issue(5'b11000, 3'd5, 3'd6, 3'd7, 16'hFFFC, 1'b0);     // VLD, toggling ack
    ack_mode = 1;
    issue(5'b11001, 3'd1, 3'd2, 3'd4, 16'h1234, 1'b1);     // VST, ack tied high
    issue(5'b11010, 3'd3, 3'd3, 3'd3, 16'h0000, 1'b1);     // illegal
    issue(5'b10101, 3'd7, 3'd0, 3'd6, 16'h0000, 1'b1);     // legal accept clears err

    // Reset in the middle of EXEC at element 4.
    for (int i = 0; i < 5; i++) exp_q.push_back(mk(2'd0, 16'd0, 3'd4, 3'(i), 3'd3, 3'd2, 3'd1, 1'b0, 1'b0));
    VPU_start = 1'b1; opcode = 5'b10011; vd = 3'd4; vs = 3'd2; vt = 3'd1;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc >= 2 && elem_idx == 3'd4) break;
      if (cyc > 50) begin
        n_total++;
        $display("FAIL reach_idx4: got idx %0d expected 4 within 50 cycles", elem_idx);
        break;
      end
    end
    #1 rst = 1'b1; VPU_start = 1'b0;
    @(negedge clk);
    chk("rst_mid_idx", 64'(elem_idx), 64'd0);
    chk("rst_mid_vrf_we", 64'(vrf_we), 64'd0);
    chk("rst_mid_rdy", 64'(VPU_rdy), 64'd1);
    chk("rst_mid_mem_req", 64'(mem_req), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    issue(5'b10001, 3'd6, 3'd5, 3'd4, 16'h0000, 1'b1);

    // Randomized instruction stream.
    for (int k = 0; k < 40; k++) begin
      int sel = $urandom_range(0, 7);
      logic [4:0] op;
      logic [15:0] base;
      bit is_mem;
      if (sel < 4)      op = 5'(16 + $urandom_range(0, 7));
      else if (sel < 6) op = 5'(24 + $urandom_range(0, 1));
      else if (sel == 6) op = 5'($urandom_range(0, 15));
      else              op = 5'($urandom_range(26, 31));
      is_mem = (op == 5'd24) || (op == 5'd25);
      base = ($urandom_range(0, 1) == 1) ? 16'(16'hFFF8 + $urandom_range(0, 7))
                                         : 16'($urandom_range(0, 65535));
      ack_mode = $urandom_range(0, 1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      issue(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            base, !(is_mem && ack_mode == 0));
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
